hog_block_norm: RTL

L1-normalisation stage directly downstream of the HOG histogram unit. It accepts one set of four 9-bin block histograms (36 bins) together with its row/column tag. It computes the L1 norm and emits the 36 bins serially as 8-bit values scaled to 0..255. The output is a valid/ready stream toward the feature packer.

---
 rtl/hog_block_norm.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/hog_block_norm.sv
// rtl/hog_block_norm.sv - L1 normalisation of a 36-bin HOG block set to 8-bit serial output
module hog_block_norm #(
    parameter int BIN_W = 20,
    parameter int NBINS = 9,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             cnt_row,
    input  logic [5:0]             cnt_col,
    input  logic [BIN_W*NBINS-1:0] hist_0,
    input  logic [BIN_W*NBINS-1:0] hist_1,
    input  logic [BIN_W*NBINS-1:0] hist_2,
    input  logic [BIN_W*NBINS-1:0] hist_3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_bin,
    output logic [5:0]             out_idx,
    output logic [7:0]             out_row,
    output logic [5:0]             out_col,
    output logic                   out_last
);

    localparam int NTOT   = 4 * NBINS;
    localparam int NORM_W = BIN_W + 6;
    localparam int NUM_W  = BIN_W + OUT_W;
    localparam int CNT_W  = $clog2(OUT_W);
    localparam logic [5:0]       LAST_IDX = 6'(NTOT - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_DIV, S_OUT} state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    bins_q [NTOT];
    logic [BIN_W-1:0]    bins_d [NTOT];
    logic [7:0]          row_q, row_d;
    logic [5:0]          col_q, col_d;
    logic [NORM_W-1:0]   norm_q, norm_d;
    logic [5:0]          idx_q, idx_d;
    logic [1:0]          blk_q, blk_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NORM_W-1:0]   rem_q, rem_d;
    logic [OUT_W-1:0]    numlo_q, numlo_d;
    logic [OUT_W-1:0]    quo_q, quo_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_bin_q, out_bin_d;
    logic                out_last_q, out_last_d;
    logic                in_ready_q, in_ready_d;

    logic [4*BIN_W*NBINS-1:0] hist_all;
    logic [NORM_W-1:0]        blk_sum;
    logic [NORM_W-1:0]        norm_sum;
    logic [5:0]               ld_idx;
    logic [BIN_W-1:0]         ld_bin;
    logic [NUM_W-1:0]         ld_num;
    logic [NORM_W:0]          trial;
    logic                     take;

    assign hist_all = {hist_3, hist_2, hist_1, hist_0};

    // Datapath helpers: block partial sum, next dividend (bin*255) and one restoring-divide step
    always_comb begin
        blk_sum = '0;
        for (int j = 0; j < NBINS; j++) begin
            blk_sum = blk_sum + NORM_W'(bins_q[int'(blk_q) * NBINS + j]);
        end
        norm_sum = norm_q + blk_sum;
        // Dividend is loaded for idx 0 when leaving SUM, else for the bin after the one just sent
        ld_idx   = (state_q == S_OUT && idx_q != LAST_IDX) ? idx_q + 6'd1 : 6'd0;
        ld_bin   = bins_q[ld_idx];
        ld_num   = {ld_bin, {OUT_W{1'b0}}} - NUM_W'(ld_bin);
        trial    = {rem_q, numlo_q[OUT_W-1]};
        take     = (trial >= {1'b0, norm_q});
    end

    // Next-state and register update logic for the IDLE/SUM/DIV/OUT sequencer
    always_comb begin
        state_d     = state_q;
        bins_d      = bins_q;
        row_d       = row_q;
        col_d       = col_q;
        norm_d      = norm_q;
        idx_d       = idx_q;
        blk_d       = blk_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        numlo_d     = numlo_q;
        quo_d       = quo_q;
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < NTOT; k++) begin
                        bins_d[k] = hist_all[BIN_W*k +: BIN_W];
                    end
                    row_d   = cnt_row;
                    col_d   = cnt_col;
                    norm_d  = '0;
                    blk_d   = 2'd0;
                    idx_d   = 6'd0;
                    state_d = S_SUM;
                end
            end
            S_SUM: begin
                norm_d = norm_sum;
                blk_d  = blk_q + 2'd1;
                if (blk_q == 2'd3) begin
                    idx_d = 6'd0;
                    if (norm_sum == '0) begin
                        // Empty set: skip division, all bins go out as zero
                        out_valid_d = 1'b1;
                        out_bin_d   = '0;
                        out_last_d  = 1'b0;
                        state_d     = S_OUT;
                    end else begin
                        rem_d   = NORM_W'(ld_num[NUM_W-1:OUT_W]);
                        numlo_d = ld_num[OUT_W-1:0];
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                // High dividend bits are below norm, so OUT_W steps yield the full quotient
                rem_d   = take ? NORM_W'(trial - {1'b0, norm_q}) : NORM_W'(trial);
                quo_d   = {quo_q[OUT_W-2:0], take};
                numlo_d = numlo_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    out_bin_d   = {quo_q[OUT_W-2:0], take};
                    out_valid_d = 1'b1;
                    out_last_d  = (idx_q == LAST_IDX);
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        idx_d       = 6'd0;
                        state_d     = S_IDLE;
                    end else if (norm_q == '0) begin
                        idx_d      = idx_q + 6'd1;
                        out_bin_d  = '0;
                        out_last_d = (idx_q == LAST_IDX - 6'd1);
                    end else begin
                        idx_d       = idx_q + 6'd1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rem_d       = NORM_W'(ld_num[NUM_W-1:OUT_W]);
                        numlo_d     = ld_num[OUT_W-1:0];
                        quo_d       = '0;
                        cnt_d       = '0;
                        state_d     = S_DIV;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers; reset drops any set in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int k = 0; k < NTOT; k++) begin
                bins_q[k] <= '0;
            end
            row_q       <= '0;
            col_q       <= '0;
            norm_q      <= '0;
            idx_q       <= '0;
            blk_q       <= '0;
            cnt_q       <= '0;
            rem_q       <= '0;
            numlo_q     <= '0;
            quo_q       <= '0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            bins_q      <= bins_d;
            row_q       <= row_d;
            col_q       <= col_d;
            norm_q      <= norm_d;
            idx_q       <= idx_d;
            blk_q       <= blk_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            numlo_q     <= numlo_d;
            quo_q       <= quo_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_idx   = idx_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = out_last_q;

endmodule
